// File: rtl/bsg_two_skid_buffer_width_p3_pkg.sv
// Shared sizing constants for the two-entry skid buffer.
package bsg_two_skid_buffer_width_p3_pkg;
    localparam int unsigned count_width_lp = 2;
    localparam int unsigned depth_lp       = 2;
endpackage

// File: rtl/bsg_two_entry_mem_width_p3.sv
// Two-entry register storage: one write port, one asynchronous read port.
module bsg_two_entry_mem_width_p3
    import bsg_two_skid_buffer_width_p3_pkg::*;
#(
    parameter int width_p = 3
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               w_v_i,
    input  logic               w_addr_i,
    input  logic [width_p-1:0] w_data_i,
    input  logic               r_addr_i,
    output logic [width_p-1:0] r_data_o
);

    logic [depth_lp-1:0][width_p-1:0] mem_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_q <= '0;
        end else if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bsg_two_skid_buffer_width_p3.sv
// Two-entry FIFO skid buffer; ready_o depends only on stored occupancy, never on yumi_i.
module bsg_two_skid_buffer_width_p3
    import bsg_two_skid_buffer_width_p3_pkg::*;
#(
    parameter int width_p = 3
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      v_i,
    input  logic [width_p-1:0]        data_i,
    output logic                      ready_o,
    output logic                      v_o,
    output logic [width_p-1:0]        data_o,
    input  logic                      yumi_i,
    output logic                      en_o,
    output logic [count_width_lp-1:0] count_o
);

    localparam logic [count_width_lp-1:0] full_lp = count_width_lp'(depth_lp);
    localparam logic [count_width_lp-1:0] one_lp  = count_width_lp'(1);

    logic [count_width_lp-1:0] count_q, count_d;
    logic                      wptr_q, wptr_d;
    logic                      rptr_q, rptr_d;
    logic                      enq, deq;

    // Reset input gates ready so nothing is accepted while held, yet the
    // first edge after release can already take data.
    assign ready_o = (count_q != full_lp) & reset_n_i;
    assign v_o     = (count_q != '0);
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;
    assign en_o    = deq;
    assign count_o = count_q;

    always_comb begin
        wptr_d  = wptr_q ^ enq;
        rptr_d  = rptr_q ^ deq;
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + one_lp;
            2'b01:   count_d = count_q - one_lp;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    bsg_two_entry_mem_width_p3 #(.width_p(width_p)) mem (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .w_v_i     (enq),
        .w_addr_i  (wptr_q),
        .w_data_i  (data_i),
        .r_addr_i  (rptr_q),
        .r_data_o  (data_o)
    );

    yumi_without_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(yumi_i && !v_o));

endmodule

// File: tb/tb_bsg_two_skid_buffer_width_p3.sv
// Scoreboard bench for the two-entry skid buffer: driver pushes accepted data, monitor pops on consume.
module tb_bsg_two_skid_buffer_width_p3;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       v_i, yumi_i;
    logic [2:0] data_i;
    logic       ready_o, v_o, en_o;
    logic [2:0] data_o;
    logic [1:0] count_o;

    int         nvec = 0;
    int         nerr = 0;
    logic [2:0] sb[$];
    logic       acc;
    logic [2:0] acc_d;

    bsg_two_skid_buffer_width_p3 #(.width_p(3)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .v_o       (v_o),
        .data_o    (data_o),
        .yumi_i    (yumi_i),
        .en_o      (en_o),
        .count_o   (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change just after a posedge; acceptance is predicted from the model queue.
    task automatic drive(input logic v, input logic [2:0] d, input logic y);
        v_i    = v;
        data_i = d;
        yumi_i = y && (sb.size() != 0);
        acc    = v && reset_n_i && (sb.size() < 2);
        acc_d  = d;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (acc) sb.push_back(acc_d);
        acc = 1'b0;
    endtask

    task automatic at_mid();
        @(negedge clk_i);
        #1;
    endtask

    // Monitor: compares the DUT against the model at every negedge and pops on consume.
    always @(negedge clk_i) begin
        if (!reset_n_i) begin
            chk("rst_ready", ready_o, 0);
            chk("rst_v", v_o, 0);
            chk("rst_count", count_o, 0);
            chk("rst_data", data_o, 0);
        end else begin
            chk("count", count_o, sb.size());
            chk("v_o", v_o, sb.size() != 0);
            chk("ready", ready_o, sb.size() != 2);
            chk("en_o", en_o, yumi_i && sb.size() != 0);
            if (sb.size() != 0) begin
                chk("data_o", data_o, sb[0]);
                if (yumi_i) void'(sb.pop_front());
            end
        end
    end

    initial begin
        acc = 1'b0; acc_d = '0;
        reset_n_i = 1'b0; v_i = 1'b1; data_i = 3'b111; yumi_i = 1'b0;

        // Reset release: v_i held high while in reset
        repeat (3) @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        drive(1'b1, 3'b100, 1'b0);
        tick();
        chk("rel_ready", ready_o, 1);
        chk("rel_data", data_o, 3'b100);
        chk("rel_count", count_o, 1);
        drive(1'b0, 3'b000, 1'b1);
        tick();

        // Fill and stall
        drive(1'b1, 3'b101, 1'b0); tick();
        drive(1'b1, 3'b011, 1'b0); tick();
        drive(1'b1, 3'b111, 1'b0);
        at_mid();
        chk("full_count", count_o, 2);
        chk("full_ready", ready_o, 0);
        chk("full_data", data_o, 3'b101);
        tick();
        chk("stall_count", count_o, 2);
        drive(1'b0, 3'b000, 1'b1); tick();
        chk("after_deq_ready", ready_o, 1);
        chk("after_deq_data", data_o, 3'b011);
        drive(1'b0, 3'b000, 1'b1); tick();
        chk("drained_v", v_o, 0);

        // Simultaneous enq/deq at count 1
        drive(1'b1, 3'b010, 1'b0); tick();
        drive(1'b1, 3'b110, 1'b1);
        at_mid();
        chk("simul_en", en_o, 1);
        tick();
        chk("simul_data", data_o, 3'b110);
        chk("simul_count", count_o, 1);
        drive(1'b0, 3'b000, 1'b1); tick();

        // Wrap-around stream with continuous consume
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 1'b1);
            tick();
            chk("stream_data", data_o, i);
            chk("stream_count_le1", count_o <= 2'd1, 1);
        end
        drive(1'b0, 3'b000, 1'b1); tick();
        chk("stream_empty", v_o, 0);

        // Mid-operation asynchronous reset at count 2
        drive(1'b1, 3'b001, 1'b0); tick();
        drive(1'b1, 3'b110, 1'b0); tick();
        drive(1'b0, 3'b000, 1'b0);
        #1 reset_n_i = 1'b0;
        #1;
        chk("mid_rst_v", v_o, 0);
        chk("mid_rst_count", count_o, 0);
        chk("mid_rst_data", data_o, 0);
        chk("mid_rst_ready", ready_o, 0);
        sb.delete();
        #1 reset_n_i = 1'b1;
        tick();
        chk("post_rst_v", v_o, 0);
        chk("post_rst_data", data_o, 0);
        drive(1'b1, 3'b011, 1'b0); tick();
        chk("post_rst_first", data_o, 3'b011);
        drive(1'b0, 3'b000, 1'b1); tick();

        // Random traffic against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'b000, 1'b1);
            tick();
        end
        chk("final_empty", v_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
